// File: rtl/nes_cpu_bus_responder.sv
// CPU-side bus responder for the 2A03: address decode, 2 KiB work RAM with mirrors,
// PPU/external forwarding, and the $4014 OAM DMA engine that halts the CPU via Ready.
module nes_cpu_bus_responder #(
    parameter int          RAM_AW  = 11,
    parameter logic [15:0] DMA_REG = 16'h4014,
    parameter logic [2:0]  OAM_REG = 3'd4
) (
    input  logic        clock,
    input  logic        RST,
    input  logic        cpu_en,
    input  logic [15:0] cpu_addr,
    input  logic        RorW,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        Ready,
    output logic        ppu_sel,
    output logic        ppu_we,
    output logic [2:0]  ppu_reg,
    output logic [7:0]  ppu_wdata,
    input  logic [7:0]  ppu_rdata,
    output logic        ext_sel,
    output logic        ext_we,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata
);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

    dma_state_t state, state_next;

    logic              odd;
    logic [7:0]        page;
    logic [7:0]        idx;
    logic [7:0]        dma_buf;
    logic [7:0]        ram [2**RAM_AW];
    logic [RAM_AW-1:0] ram_idx;
    logic [7:0]        ram_rdata;
    logic [15:0]       dma_src;
    logic              dma_ram;
    logic              cpu_acc;
    logic              hit_dma;
    logic              hit_ram;
    logic              hit_ppu;
    logic              hit_ext;
    logic              dma_start;
    logic              rd_load;
    logic [7:0]        rd_data;

    // The CPU only sees the bus while no DMA is running; reset blocks it too.
    assign Ready     = (state == IDLE);
    assign cpu_acc   = cpu_en && Ready && !RST;
    assign hit_dma   = (cpu_addr == DMA_REG);
    assign hit_ram   = !hit_dma && (cpu_addr[15:13] == 3'b000);
    assign hit_ppu   = !hit_dma && (cpu_addr[15:13] == 3'b001);
    assign hit_ext   = !hit_dma && !hit_ram && !hit_ppu;
    assign dma_start = cpu_acc && hit_dma && !RorW;

    assign dma_src   = {page, idx};
    assign dma_ram   = (page[7:5] == 3'b000);
    assign ram_idx   = (state == READ) ? dma_src[RAM_AW-1:0] : cpu_addr[RAM_AW-1:0];
    assign ram_rdata = ram[ram_idx];

    assign rd_load   = cpu_acc && RorW && !hit_dma;
    assign rd_data   = hit_ram ? ram_rdata : (hit_ppu ? ppu_rdata : ext_rdata);

    always_ff @(posedge clock) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ppu_sel    = 1'b0;
        ppu_we     = 1'b0;
        ppu_reg    = 3'd0;
        ppu_wdata  = 8'h00;
        ext_sel    = 1'b0;
        ext_we     = 1'b0;
        ext_addr   = 16'h0000;
        ext_wdata  = 8'h00;

        case (state)
            IDLE:  if (dma_start) state_next = HALT;
            HALT:  state_next = odd ? ALIGN : READ;
            ALIGN: state_next = READ;
            READ: begin
                if (!dma_ram) begin
                    ext_sel  = 1'b1;
                    ext_addr = dma_src;
                end
                state_next = WRITE;
            end
            WRITE: begin
                ppu_sel    = 1'b1;
                ppu_we     = 1'b1;
                ppu_reg    = OAM_REG;
                ppu_wdata  = dma_buf;
                state_next = (idx == 8'hFF) ? IDLE : READ;
            end
            default: state_next = IDLE;
        endcase

        if (cpu_acc && hit_ppu) begin
            ppu_sel   = 1'b1;
            ppu_we    = ~RorW;
            ppu_reg   = cpu_addr[2:0];
            ppu_wdata = cpu_wdata;
        end else if (cpu_acc && hit_ext) begin
            ext_sel   = 1'b1;
            ext_we    = ~RorW;
            ext_addr  = cpu_addr;
            ext_wdata = cpu_wdata;
        end

        if (RST) begin
            ppu_sel   = 1'b0;
            ppu_we    = 1'b0;
            ppu_reg   = 3'd0;
            ppu_wdata = 8'h00;
            ext_sel   = 1'b0;
            ext_we    = 1'b0;
            ext_addr  = 16'h0000;
            ext_wdata = 8'h00;
        end
    end

    // Datapath: read-data register, parity, DMA page/index and the one-byte buffer.
    always_ff @(posedge clock) begin
        if (RST) begin
            cpu_rdata <= 8'h00;
            odd       <= 1'b0;
            page      <= 8'h00;
            idx       <= 8'h00;
            dma_buf   <= 8'h00;
        end else begin
            odd <= ~odd;
            if (rd_load) cpu_rdata <= rd_data;
            if (dma_start) begin
                page <= cpu_wdata;
                idx  <= 8'h00;
            end
            if (state == READ)  dma_buf <= dma_ram ? ram_rdata : ext_rdata;
            if (state == WRITE) idx <= idx + 8'd1;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (cpu_acc && hit_ram && !RorW) ram[cpu_addr[RAM_AW-1:0]] <= cpu_wdata;
    end

endmodule

// File: tb/tb_nes_cpu_bus_responder.sv
// Directed self-checking bench for nes_cpu_bus_responder: decode, mirroring,
// open bus, OAM DMA from RAM and ext with parity alignment, lockout, reset abort.
module tb_nes_cpu_bus_responder;

    logic        clock;
    logic        RST;
    logic        cpu_en;
    logic [15:0] cpu_addr;
    logic        RorW;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        Ready;
    logic        ppu_sel;
    logic        ppu_we;
    logic [2:0]  ppu_reg;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata;
    logic        ext_sel;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;

    int n_checks;
    int n_fails;

    logic       tb_odd;
    logic [7:0] tb_mem [2048];

    int         d_halted;
    int         d_pulses;
    int         d_bad_data;
    int         d_ext_reads;
    int         d_bad_ext;
    int         d_bad_timing;
    logic [7:0] d_first;
    logic [7:0] d_last;
    int         d_timeout;
    int         exp_halt;
    int         not_ready;

    nes_cpu_bus_responder dut (
        .clock     (clock),
        .RST       (RST),
        .cpu_en    (cpu_en),
        .cpu_addr  (cpu_addr),
        .RorW      (RorW),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .Ready     (Ready),
        .ppu_sel   (ppu_sel),
        .ppu_we    (ppu_we),
        .ppu_reg   (ppu_reg),
        .ppu_wdata (ppu_wdata),
        .ppu_rdata (ppu_rdata),
        .ext_sel   (ext_sel),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata)
    );

    // Cartridge model: data is a fixed function of the address it is asked for.
    assign ext_rdata = ext_addr[15:8] ^ ext_addr[7:0] ^ 8'hC3;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, tracking the parity bit the DUT should hold.
    task automatic step();
        @(posedge clock);
        tb_odd = RST ? 1'b0 : ~tb_odd;
        #1;
    endtask

    task automatic apply_stimulus(input logic en, input logic [15:0] addr, input logic rw, input logic [7:0] wd);
        cpu_en    = en;
        cpu_addr  = addr;
        RorW      = rw;
        cpu_wdata = wd;
    endtask

    task automatic cycle(input logic en, input logic [15:0] addr, input logic rw, input logic [7:0] wd);
        apply_stimulus(en, addr, rw, wd);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] wd);
        cycle(1'b1, addr, 1'b0, wd);
        if (addr < 16'h2000) tb_mem[addr[10:0]] = wd;
        step();
    endtask

    task automatic cpu_read(input logic [15:0] addr);
        cycle(1'b1, addr, 1'b1, 8'h00);
        step();
        apply_stimulus(1'b0, 16'h0000, 1'b1, 8'h00);
    endtask

    // Trigger a DMA from the current cycle and watch it until Ready returns.
    task automatic dma_run(input logic [7:0] page, input bit lockout, input int abort_at);
        logic [7:0] exp_b;
        bit         prev_ext_ok;
        bit         cur_ext_ok;
        int         k;
        d_halted = 0; d_pulses = 0; d_bad_data = 0; d_ext_reads = 0;
        d_bad_ext = 0; d_bad_timing = 0; d_first = 8'h00; d_last = 8'h00;
        d_timeout = 1;
        prev_ext_ok = 1'b0;
        apply_stimulus(1'b1, 16'h4014, 1'b0, page);
        for (int c = 0; c < 1200; c++) begin
            step();
            if (Ready) begin
                apply_stimulus(1'b0, 16'h0000, 1'b1, 8'h00);
                if (c > 0) begin
                    d_timeout = 0;
                    break;
                end
            end else begin
                d_halted++;
                if (lockout) begin
                    case (c % 4)
                        0:       apply_stimulus(1'b1, 16'h0000, 1'b0, 8'hFF);
                        1:       apply_stimulus(1'b1, 16'h4014, 1'b0, 8'h00);
                        2:       apply_stimulus(1'b1, 16'h6000, 1'b1, 8'h00);
                        default: apply_stimulus(1'b1, 16'h2002, 1'b1, 8'h00);
                    endcase
                end else begin
                    apply_stimulus(1'b0, 16'h0000, 1'b1, 8'h00);
                end
            end
            #1;
            cur_ext_ok = 1'b0;
            if (ext_sel) begin
                if (page < 8'h20) d_bad_ext++;
                else begin
                    if (ext_we || ext_addr != {page, 8'(d_ext_reads)}) d_bad_ext++;
                    else cur_ext_ok = 1'b1;
                    d_ext_reads++;
                end
            end
            if (ppu_sel && ppu_we) begin
                k = d_pulses;
                exp_b = (page < 8'h20) ? tb_mem[{page[2:0], k[7:0]}] : (page ^ k[7:0] ^ 8'hC3);
                if (ppu_reg != 3'd4 || ppu_wdata != exp_b) d_bad_data++;
                if (page >= 8'h20 && (!prev_ext_ok || d_ext_reads != k + 1)) d_bad_timing++;
                if (d_pulses == 0) d_first = ppu_wdata;
                d_last = ppu_wdata;
                d_pulses++;
                if (k == abort_at) begin
                    RST = 1'b1;
                    d_timeout = 0;
                    break;
                end
            end else if (ppu_sel) begin
                d_bad_data++;
            end
            prev_ext_ok = cur_ext_ok;
        end
    endtask

    // Watchdog so a wedged run still ends with a reported failure.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        tb_odd   = 1'b0;
        RST      = 1'b1;
        ppu_rdata = 8'h00;
        apply_stimulus(1'b0, 16'h0000, 1'b1, 8'h00);

        // Reset: strobes and data outputs stay low even with a PPU write pending.
        step();
        step();
        cycle(1'b1, 16'h2000, 1'b0, 8'h55);
        check_output("rst_ready",     32'(Ready),     32'd1);
        check_output("rst_rdata",     32'(cpu_rdata), 32'h00);
        check_output("rst_ppu_sel",   32'(ppu_sel),   32'd0);
        check_output("rst_ppu_we",    32'(ppu_we),    32'd0);
        check_output("rst_ppu_reg",   32'(ppu_reg),   32'd0);
        check_output("rst_ppu_wdata", 32'(ppu_wdata), 32'h00);
        check_output("rst_ext_sel",   32'(ext_sel),   32'd0);
        check_output("rst_ext_addr",  32'(ext_addr),  32'h0000);
        check_output("rst_ext_wdata", 32'(ext_wdata), 32'h00);
        step();
        RST = 1'b0;
        apply_stimulus(1'b0, 16'h0000, 1'b1, 8'h00);

        // RAM mirroring: a write is visible through every 2 KiB mirror.
        cycle(1'b1, 16'h0001, 1'b0, 8'hA5);
        tb_mem[1] = 8'hA5;
        check_output("ram_wr_no_ppu", 32'(ppu_sel), 32'd0);
        check_output("ram_wr_no_ext", 32'(ext_sel), 32'd0);
        step();
        cpu_read(16'h0801);
        check_output("mirror_0801", 32'(cpu_rdata), 32'hA5);
        cpu_write(16'h07FF, 8'h3C);
        cpu_read(16'h1001);
        check_output("mirror_1001", 32'(cpu_rdata), 32'hA5);
        cpu_read(16'h1FFF);
        check_output("mirror_1fff", 32'(cpu_rdata), 32'h3C);
        cpu_read(16'h1801);
        check_output("mirror_1801", 32'(cpu_rdata), 32'hA5);

        // PPU window, mirrored every 8 bytes.
        ppu_rdata = 8'h3C;
        cycle(1'b1, 16'h3FFA, 1'b1, 8'h00);
        check_output("ppu_rd_sel", 32'(ppu_sel), 32'd1);
        check_output("ppu_rd_we",  32'(ppu_we),  32'd0);
        check_output("ppu_rd_reg", 32'(ppu_reg), 32'd2);
        check_output("ppu_rd_ext", 32'(ext_sel), 32'd0);
        step();
        ppu_rdata = 8'h00;
        check_output("ppu_rd_data", 32'(cpu_rdata), 32'h3C);
        cycle(1'b1, 16'h2007, 1'b0, 8'h99);
        check_output("ppu_wr_sel",   32'(ppu_sel),   32'd1);
        check_output("ppu_wr_we",    32'(ppu_we),    32'd1);
        check_output("ppu_wr_reg",   32'(ppu_reg),   32'd7);
        check_output("ppu_wr_wdata", 32'(ppu_wdata), 32'h99);
        step();

        // External bus: read $6000 gives 60^00^C3 = A3.
        cycle(1'b1, 16'h6000, 1'b1, 8'h00);
        check_output("ext_rd_sel",  32'(ext_sel),  32'd1);
        check_output("ext_rd_we",   32'(ext_we),   32'd0);
        check_output("ext_rd_addr", 32'(ext_addr), 32'h6000);
        step();
        check_output("ext_rd_data", 32'(cpu_rdata), 32'hA3);
        cycle(1'b1, 16'h4017, 1'b0, 8'h5E);
        check_output("ext_wr_sel",   32'(ext_sel),   32'd1);
        check_output("ext_wr_we",    32'(ext_we),    32'd1);
        check_output("ext_wr_addr",  32'(ext_addr),  32'h4017);
        check_output("ext_wr_wdata", 32'(ext_wdata), 32'h5E);
        check_output("ext_wr_noppu", 32'(ppu_sel),   32'd0);
        step();

        // Open bus: reading $4014 touches nothing and keeps the last read value.
        cycle(1'b1, 16'h4014, 1'b1, 8'h00);
        check_output("ob_ext_sel", 32'(ext_sel), 32'd0);
        check_output("ob_ppu_sel", 32'(ppu_sel), 32'd0);
        step();
        apply_stimulus(1'b0, 16'h0000, 1'b1, 8'h00);
        check_output("ob_rdata", 32'(cpu_rdata), 32'hA3);
        check_output("ob_no_dma", 32'(Ready), 32'd1);

        // DMA from RAM page $02 with CPU lockout traffic, even HALT parity.
        cpu_write(16'h0000, 8'h11);
        for (int i = 0; i < 256; i++) cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'h5A);
        cpu_read(16'h0000);
        check_output("pre_dma_rdata", 32'(cpu_rdata), 32'h11);
        if (tb_odd != 1'b1) step();
        exp_halt = tb_odd ? 513 : 514;
        check_output("ram_dma_parity_setup", 32'(exp_halt), 32'd513);
        dma_run(8'h02, 1'b1, -1);
        check_output("ram_dma_timeout",  32'(d_timeout),  32'd0);
        check_output("ram_dma_halt",     32'(d_halted),   32'(exp_halt));
        check_output("ram_dma_pulses",   32'(d_pulses),   32'd256);
        check_output("ram_dma_bad_data", 32'(d_bad_data), 32'd0);
        check_output("ram_dma_first",    32'(d_first),    32'h5A);
        check_output("ram_dma_last",     32'(d_last),     32'hA5);
        check_output("ram_dma_no_ext",   32'(d_bad_ext),  32'd0);
        check_output("lockout_rdata",    32'(cpu_rdata),  32'h11);
        not_ready = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!Ready) not_ready++;
        end
        check_output("lockout_no_2nd_dma", 32'(not_ready), 32'd0);
        cpu_read(16'h0000);
        check_output("lockout_ram_kept", 32'(cpu_rdata), 32'h11);

        // DMA from ext page $80 with odd HALT parity -> ALIGN inserted.
        if (tb_odd != 1'b0) step();
        exp_halt = tb_odd ? 513 : 514;
        dma_run(8'h80, 1'b0, -1);
        check_output("ext_dma_timeout",  32'(d_timeout),    32'd0);
        check_output("ext_dma_halt",     32'(d_halted),     32'd514);
        check_output("ext_dma_halt_mdl", 32'(d_halted),     32'(exp_halt));
        check_output("ext_dma_reads",    32'(d_ext_reads),  32'd256);
        check_output("ext_dma_bad_ext",  32'(d_bad_ext),    32'd0);
        check_output("ext_dma_pulses",   32'(d_pulses),     32'd256);
        check_output("ext_dma_bad_data", 32'(d_bad_data),   32'd0);
        check_output("ext_dma_timing",   32'(d_bad_timing), 32'd0);
        check_output("ext_dma_first",    32'(d_first),      32'h43);

        // Reset at the WRITE of i=40 aborts the transfer.
        cpu_read(16'h0001);
        check_output("pre_abort_rdata", 32'(cpu_rdata), 32'hA5);
        dma_run(8'h02, 1'b0, 40);
        check_output("abort_reached", 32'(d_pulses), 32'd41);
        step();
        cycle(1'b1, 16'h2000, 1'b0, 8'h77);
        check_output("abort_ready",   32'(Ready),     32'd1);
        check_output("abort_rdata",   32'(cpu_rdata), 32'h00);
        check_output("abort_ppu_sel", 32'(ppu_sel),   32'd0);
        check_output("abort_ext_sel", 32'(ext_sel),   32'd0);
        step();
        RST = 1'b0;
        apply_stimulus(1'b0, 16'h0000, 1'b1, 8'h00);
        exp_halt = tb_odd ? 513 : 514;
        dma_run(8'h02, 1'b0, -1);
        check_output("restart_timeout",  32'(d_timeout),  32'd0);
        check_output("restart_halt",     32'(d_halted),   32'(exp_halt));
        check_output("restart_pulses",   32'(d_pulses),   32'd256);
        check_output("restart_first",    32'(d_first),    32'h5A);
        check_output("restart_bad_data", 32'(d_bad_data), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/nes_cpu_bus_responder.md
# nes_cpu_bus_responder

Responder side of the 2A03 CPU bus. Decodes every CPU access, serves the 2 KiB internal work RAM with its mirrors, forwards the $2000–$3FFF window to the PPU register port, and routes everything else to the cartridge/APU bus. It also owns OAM DMA: a write to $4014 halts the CPU through `Ready` and copies one 256-byte page into PPU OAM via $2004.

## Interface
Parameters:
- `RAM_AW`, default 11: internal RAM address width (2 KiB).
- `DMA_REG`, default 16'h4014: OAM DMA trigger address.
- `OAM_REG`, default 3'd4: PPU register index that receives DMA bytes.

Ports:
- `clock` input 1: single system clock; all state updates on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `cpu_en` input 1: CPU performs a bus access this cycle.
- `cpu_addr` input 16: CPU address.
- `RorW` input 1: 1 = read, 0 = write.
- `cpu_wdata` input 8: CPU write data.
- `cpu_rdata` output 8: registered read data to CPU.
- `Ready` output 1: registered; 1 = CPU may proceed, 0 = CPU halted.
- `ppu_sel` output 1: PPU register access strobe.
- `ppu_we` output 1: PPU write.
- `ppu_reg` output 3: PPU register index.
- `ppu_wdata` output 8: PPU write data.
- `ppu_rdata` input 8: PPU read data (combinational, same cycle).
- `ext_sel` output 1: cartridge/APU access strobe.
- `ext_we` output 1: external write.
- `ext_addr` output 16: external address.
- `ext_wdata` output 8: external write data.
- `ext_rdata` input 8: external read data (combinational, same cycle).

## Operation
- Address map, decoded only when `cpu_en=1` and `Ready=1`:
  - $0000–$1FFF: RAM at `cpu_addr[10:0]`.
  - $2000–$3FFF: PPU, with `ppu_reg = cpu_addr[2:0]`.
  - `DMA_REG`: write starts DMA with page P = `cpu_wdata`. A read returns open bus.
  - All other addresses: ext, with `ext_addr = cpu_addr`.
- Strobes:
  - `ppu_sel`, `ppu_we`, `ext_sel`, `ext_we` are combinational, asserted only in the access cycle.
  - `ppu_we = ext_we = ~RorW`.
  - All strobes are forced to 0 while `RST=1`.
- Read data: `cpu_rdata` loads at the edge ending the read cycle from RAM, `ppu_rdata` or `ext_rdata`.
  - Open-bus reads ($4014, or any cycle with no read) leave `cpu_rdata` unchanged.
- Parity bit `odd`:
  - Reset value 0; toggles every cycle.
  - The DMA alignment decision uses it.
- DMA FSM states are IDLE, HALT, ALIGN, READ and WRITE, with an 8-bit index `i`.
  - IDLE → HALT on a CPU write to `DMA_REG`; latch P and set `i=0`.
  - HALT → ALIGN if `odd=1` in the HALT cycle, otherwise HALT → READ.
  - ALIGN → READ.
  - READ: source address {P, i}. Pages $00–$1F read RAM at {P[2:0], i}. Other pages drive `ext_sel=1`, `ext_we=0`, `ext_addr={P,i}`. The byte is latched into the DMA buffer at the end of the cycle.
  - READ → WRITE.
  - WRITE: `ppu_sel=1`, `ppu_we=1`, `ppu_reg=OAM_REG`, `ppu_wdata=buffer`.
  - WRITE → READ with `i+1`, or WRITE → IDLE when `i=255` (`i` wraps to 0).
- Halting:
  - `Ready=0` from the HALT cycle through the final WRITE cycle.
  - During that period, CPU inputs are ignored entirely: no RAM writes, no strobes, no `cpu_rdata` update.
  - A $4014 write seen while `Ready=0` is ignored.
- Reset:
  - Reset mid-DMA aborts to IDLE.
  - `Ready=1`, `cpu_rdata=8'h00`, `odd=0`, `i=0`.
  - RAM contents are not cleared.

## Timing
- Reset values: `Ready=1`, `cpu_rdata=0`, all strobes 0, `ppu_reg=0`, `ppu_wdata=0`, `ext_addr=0`, `ext_wdata=0`.
- Read latency is 1 cycle: a read in cycle t gives valid `cpu_rdata` from cycle t+1, held until the next read.
- RAM write in cycle t is readable by a read issued in cycle t+1.
- DMA timing:
  - Trigger write in cycle t; `Ready` falls at t+1 (HALT).
  - Halt length is 513 cycles (HALT + 512), or 514 when ALIGN is inserted.
  - `Ready` rises in the cycle after the 256th WRITE.
- OAM write k (k = 0..255) carries source byte {P, k} and occurs exactly one cycle after its READ.

## Test plan
- Mirroring: write 8'hA5 to $0001, then read $0801, $1001 and $1801 → each read returns 8'hA5 one cycle later.
- PPU window:
  - Read $3FFA with `ppu_rdata=8'h3C` → `ppu_sel=1`, `ppu_we=0`, `ppu_reg=2` that cycle; `cpu_rdata=8'h3C` next cycle.
  - Write $2007 → `ppu_we=1`, `ppu_reg=7`.
- DMA from RAM:
  - Fill $0200–$02FF with i^8'h5A, then write 8'h02 to $4014 with even HALT parity.
  - → `Ready=0` for exactly 513 cycles.
  - → 256 `ppu_we` pulses at `ppu_reg=4` carrying 8'h5A, 8'h5B, …
- DMA alignment and ext source:
  - Trigger with 8'h80 and odd HALT parity.
  - → 514 halted cycles; `ext_addr` runs $8000..$80FF with `ext_we=0`; OAM data equals `ext_rdata`.
- CPU lockout: during DMA, drive `cpu_en=1` writes to $0000 and a second $4014 write → RAM is unchanged, no extra DMA occurs, and `cpu_rdata` is unchanged.
- Reset mid-DMA: assert `RST` at WRITE of i=40 → next cycle `Ready=1`, strobes 0, `cpu_rdata=0`; a fresh $4014 write restarts at i=0.
